// File: rtl/spi_master_ctrl.sv
// SPI master: one word per valid/ready accept, sclk divided from pclk, CPOL/CPHA selectable.
// Bit order: MSB first by default; define SPI_MASTER_LSB_FIRST_EN to shift LSB first.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi0,
    input  logic                  miso0
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(2 * DATA_WIDTH - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_master_ctrl: CLK_DIV must be at least 1");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
        $error("spi_master_ctrl: DATA_WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [EDGE_W-1:0]     r_edge, w_edge_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic                  r_cs, w_cs_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  w_accept, w_tc, w_edge_evt, w_lead, w_sample, w_shift_evt;

    function automatic logic f_tx_bit(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return v[0];
`else
        return v[DATA_WIDTH-1];
`endif
    endfunction

    // Sampling and transmit share one register: each capture also exposes the next bit to send.
    function automatic logic [DATA_WIDTH-1:0] f_shift_in(input logic [DATA_WIDTH-1:0] v,
                                                         input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return {b, v[DATA_WIDTH-1:1]};
`else
        return {v[DATA_WIDTH-2:0], b};
`endif
    endfunction

    assign tx_ready = (r_state == S_IDLE) && !areset;
    assign busy     = (r_state != S_IDLE);
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign mosi0    = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    assign w_accept   = tx_valid && tx_ready;
    assign w_tc       = (r_cnt == CNT_MAX);
    // The SETUP terminal count produces edge 1; SHIFT's final half-period produces none.
    assign w_edge_evt = w_tc && ((r_state == S_SETUP) ||
                                 ((r_state == S_SHIFT) && (r_edge != EDGE_LAST)));
    assign w_lead      = ~r_edge[0];
    assign w_sample    = CPHA ? !w_lead : w_lead;
    assign w_shift_evt = CPHA ? w_lead : (!w_lead && (r_edge != EDGE_PEN));

    always_ff @(posedge pclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP: if (w_tc) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_tc && (r_edge == EDGE_LAST)) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_edge_nxt     = r_edge;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_sclk_nxt     = r_sclk;
        w_cs_nxt       = r_cs;
        w_mosi_nxt     = r_mosi;
        w_rx_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_edge_nxt = '0;
                w_sclk_nxt = CPOL;
                if (w_accept) begin
                    w_cs_nxt    = 1'b0;
                    w_shift_nxt = tx_data;
                    if (!CPHA) w_mosi_nxt = f_tx_bit(tx_data);
                end
            end
            S_SETUP, S_SHIFT: begin
                w_cnt_nxt = w_tc ? '0 : r_cnt + 1'b1;
                if (w_edge_evt) begin
                    w_edge_nxt = r_edge + 1'b1;
                    w_sclk_nxt = ~r_sclk;
                    if (w_sample)    w_shift_nxt = f_shift_in(r_shift, miso0);
                    if (w_shift_evt) w_mosi_nxt  = f_tx_bit(r_shift);
                end
            end
            S_HOLD: begin
                w_cnt_nxt  = w_tc ? '0 : r_cnt + 1'b1;
                w_sclk_nxt = CPOL;
                if (w_tc) begin
                    w_cs_nxt       = 1'b1;
                    w_rx_data_nxt  = r_shift;
                    w_rx_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_sclk_nxt = CPOL;
                w_cs_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            r_cnt      <= '0;
            r_edge     <= '0;
            r_sclk     <= CPOL;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_edge     <= w_edge_nxt;
            r_sclk     <= w_sclk_nxt;
            r_cs       <= w_cs_nxt;
            r_mosi     <= w_mosi_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        r_shift <= w_shift_nxt;
    end

endmodule
